// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one tri-state SRAM port between two valid/ready requesters.
// Each op runs IDLE -> ACCESS -> DONE; out-of-range addresses skip ACCESS and return an error.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp1_err,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  id_q, id_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_oe_q, mem_oe_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  gnt0, gnt1;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  in_range;

  // prio_q names the requester that wins a tie; it flips to the other side on every accept.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle) begin
      if (req0_valid && (!req1_valid || !prio_q)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign acc_we     = gnt1 ? req1_we    : req0_we;
  assign acc_addr   = gnt1 ? req1_addr  : req0_addr;
  assign acc_wdata  = gnt1 ? req1_wdata : req0_wdata;
  assign in_range   = 32'(acc_addr) < DEPTH;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    id_d         = id_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    mem_cs_d     = mem_cs_q;
    mem_we_d     = mem_we_q;
    mem_oe_d     = mem_oe_q;
    mem_addr_d   = mem_addr_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (gnt0 || gnt1) begin
          id_d    = gnt1;
          we_d    = acc_we;
          wdata_d = acc_wdata;
          prio_d  = ~gnt1;
          if (in_range) begin
            state_d    = StAccess;
            mem_cs_d   = 1'b1;
            mem_we_d   = acc_we;
            mem_oe_d   = ~acc_we;
            mem_addr_d = acc_addr;
          end else begin
            state_d      = StDone;
            rsp0_valid_d = gnt0;
            rsp1_valid_d = gnt1;
            rsp_rdata_d  = '0;
            rsp_err_d    = 1'b1;
          end
        end
      end
      StAccess: begin
        state_d      = StDone;
        mem_cs_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_oe_d     = 1'b0;
        rsp0_valid_d = ~id_q;
        rsp1_valid_d = id_q;
        rsp_rdata_d  = we_q ? '0 : mem_data;
        rsp_err_d    = 1'b0;
      end
      StDone: begin
        state_d      = StIdle;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      prio_q       <= 1'b0;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_oe_q     <= 1'b0;
      mem_addr_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      id_q         <= id_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_oe_q     <= mem_oe_d;
      mem_addr_q   <= mem_addr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign mem_cs     = mem_cs_q;
  assign mem_we     = mem_we_q;
  assign mem_oe     = mem_oe_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = (mem_cs_q && mem_we_q) ? wdata_q : {DATA_WIDTH{1'bz}};

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_valid_q ? rsp_rdata_q : '0;
  assign rsp1_rdata = rsp1_valid_q ? rsp_rdata_q : '0;
  assign rsp0_err   = rsp0_valid_q & rsp_err_q;
  assign rsp1_err   = rsp1_valid_q & rsp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses from a word-level
// memory model, a monitor pops them against DUT responses; an SRAM model sits on the bus.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_we;
  logic [15:0] req0_addr;
  logic [3:0]  req0_wdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [15:0] req1_addr;
  logic [3:0]  req1_wdata;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [3:0]  rsp0_rdata, rsp1_rdata;
  logic        mem_cs, mem_we, mem_oe;
  logic [15:0] mem_addr;
  wire  [3:0]  mem_data;

  mem_port_arbiter #(.DATA_WIDTH(4), .ADDR_WIDTH(16), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
    .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SRAM model: commits on posedge, drives read data after the negedge while selected.
  logic [3:0] sram [16];
  logic       sram_en = 1'b0;
  logic [3:0] sram_dout = 4'h0;
  logic       probe_en = 1'b0;
  logic [3:0] probe_val = 4'h0;
  assign mem_data = (sram_en && mem_cs && mem_oe) ? sram_dout : 4'bzzzz;
  assign mem_data = probe_en ? probe_val : 4'bzzzz;

  initial begin
    for (int i = 0; i < 16; i++) sram[i] = 4'h0;
    forever begin
      @(posedge clk);
      if (mem_cs && mem_we) sram[mem_addr[3:0]] = mem_data;
    end
  end

  initial forever begin
    @(negedge clk);
    sram_en   = mem_cs && mem_oe && !mem_we;
    sram_dout = sram[mem_addr[3:0]];
  end

  // Reference model and scoreboard.
  typedef struct {
    bit         id;
    logic [3:0] rdata;
    bit         err;
    bit         we;
    logic [15:0] addr;
    logic [3:0] wdata;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] model_mem [16];
  bit         last_id = 1'b1;
  int         exp_cs = 0;
  int         cs_seen = 0;
  logic [3:0] undo_val;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic drive(input bit id, input bit we, input logic [15:0] addr,
                       input logic [3:0] wd);
    exp_t e;
    bit   done = 1'b0;
    bit   other;
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wd;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wd;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        other = id ? req0_valid : req1_valid;
        if (other) chk("rr_grant", 32'(id), 32'(!last_id));
        e.id = id; e.we = we; e.addr = addr; e.wdata = wd; e.cyc = cyc;
        e.err = (addr >= 16);
        e.rdata = 4'h0;
        if (!e.err) begin
          exp_cs++;
          if (we) begin
            undo_val = model_mem[addr[3:0]];
            model_mem[addr[3:0]] = wd;
          end else begin
            e.rdata = model_mem[addr[3:0]];
          end
        end
        last_id = id;
        exp_q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) chk("ready_timeout", 32'(id), 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    if (id == 1'b0) begin
      req0_valid = 1'b0; req0_addr = 16'($urandom); req0_wdata = 4'($urandom);
    end else begin
      req1_valid = 1'b0; req1_addr = 16'($urandom); req1_wdata = 4'($urandom);
    end
  endtask

  task automatic rand_stream(input bit id, input int n);
    for (int k = 0; k < n; k++) begin
      drive(id, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 17)), 4'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Monitor: protocol invariants, bus contents while selected, responses against scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      chk("both_ready", 32'(req0_ready & req1_ready), 0);
      chk("both_rsp", 32'(rsp0_valid & rsp1_valid), 0);
      chk("oe_we_excl", 32'(mem_oe & mem_we), 0);
      if (mem_cs) begin
        cs_seen++;
        if (exp_q.size() == 0) begin
          chk("cs_unexpected", 32'(mem_cs), 0);
        end else begin
          chk("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
          chk("mem_we", 32'(mem_we), 32'(exp_q[0].we));
          chk("mem_oe", 32'(mem_oe), 32'(!exp_q[0].we));
          if (mem_we) chk("bus_wdata", 32'(mem_data), 32'(exp_q[0].wdata));
        end
      end
      if (rsp0_valid || rsp1_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp0_valid | rsp1_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp1_valid), 32'(e.id));
          chk("rsp_rdata", 32'(e.id ? rsp1_rdata : rsp0_rdata), 32'(e.rdata));
          chk("rsp_err", 32'(e.id ? rsp1_err : rsp0_err), 32'(e.err));
          chk("rsp_latency", 32'(cyc - e.cyc), e.err ? 32'd1 : 32'd2);
        end
      end else begin
        chk("rsp_idle", 32'({rsp0_rdata, rsp0_err, rsp1_rdata, rsp1_err}), 0);
      end
      if (!mem_cs) begin
        probe_val = 4'($urandom);
        probe_en  = 1'b1;
        #1;
        chk("bus_release", 32'(mem_data), 32'(probe_val));
        probe_en  = 1'b0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) model_mem[i] = 4'h0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 16'h0; req0_wdata = 4'h0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 16'h0; req1_wdata = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({mem_cs, mem_we, mem_oe}), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 0);
    chk("rst_rdata", 32'({rsp0_rdata, rsp1_rdata}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write then read back from one requester.
    drive(1'b0, 1'b1, 16'd3, 4'hA);
    drive(1'b0, 1'b0, 16'd3, 4'h0);

    // Contending reads alternate between requesters.
    fork
      begin drive(1'b0, 1'b0, 16'd1, 4'h0); drive(1'b0, 1'b0, 16'd1, 4'h0); end
      begin drive(1'b1, 1'b0, 16'd2, 4'h0); drive(1'b1, 1'b0, 16'd2, 4'h0); end
    join

    // Out-of-range read returns an error without touching the SRAM.
    drive(1'b1, 1'b0, 16'd16, 4'h0);

    // Reset in the middle of a write: nothing committed, no response.
    drive(1'b0, 1'b1, 16'd7, 4'h3);
    drive(1'b0, 1'b1, 16'd7, 4'h5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", 32'({mem_cs, mem_we, mem_oe}), 0);
    chk("abort_addr", 32'(mem_addr), 0);
    chk("abort_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
    void'(exp_q.pop_back());
    model_mem[7] = undo_val;
    exp_cs--;
    last_id = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 16'd7, 4'h0);

    // Back-to-back write from req0 then read of the same word from req1.
    fork
      drive(1'b0, 1'b1, 16'd0, 4'hF);
      begin
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 16'd0, 4'h0);
      end
    join

    // Random traffic from both sides.
    fork
      rand_stream(1'b0, 40);
      rand_stream(1'b1, 40);
    join

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain", 32'(exp_q.size()), 0);
    chk("cs_cycles", 32'(cs_seen), 32'(exp_cs));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
